// File: rtl/hwpe_ctrl_slave.sv
// HWPE control-port TCDM slave: job-acquire lock, job config registers, job FSM and per-core completion events.
// Optional feature macro: HWPE_CTRL_PERF_CNT_EN adds a saturating RUNNING-cycle counter at word 0x14.

package hwpe_ctrl_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic [3:0]  strb;
    } periph_req_chan_t;

    typedef struct packed {
        periph_req_chan_t q;
        logic             q_valid;
    } periph_req_t;

    typedef struct packed {
        logic [31:0] data;
    } periph_rsp_chan_t;

    typedef struct packed {
        logic             q_ready;
        periph_rsp_chan_t p;
        logic             p_valid;
    } periph_rsp_t;
endpackage

module hwpe_ctrl_slave #(
    parameter int unsigned NrCores    = 9,
    parameter int unsigned NumJobRegs = 8,
    parameter type periph_req_t = hwpe_ctrl_pkg::periph_req_t,
    parameter type periph_rsp_t = hwpe_ctrl_pkg::periph_rsp_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  periph_req_t              ctrl_req_i,
    output periph_rsp_t              ctrl_rsp_o,
    output logic [NumJobRegs*32-1:0] job_regs_o,
    output logic                     start_o,
    input  logic                     done_i,
    output logic                     busy_o,
    output logic [NrCores-1:0]       evt_o
);

    localparam logic [5:0] AddrTrigger = 6'h00;
    localparam logic [5:0] AddrAcquire = 6'h01;
    localparam logic [5:0] AddrStatus  = 6'h02;
    localparam logic [5:0] AddrSoftClr = 6'h03;
    localparam logic [5:0] AddrEvtEn   = 6'h04;
`ifdef HWPE_CTRL_PERF_CNT_EN
    localparam logic [5:0] AddrPerfCyc = 6'h05;
`endif
    localparam logic [5:0] AddrJobBase = 6'h08;
    localparam logic [6:0] JobEnd      = 7'(8 + NumJobRegs);

    typedef enum logic [1:0] {Idle, Locked, Running, Done} state_e;

    state_e                         state_q;
    logic [7:0]                     jobId_q;
    logic [NrCores-1:0]             evtEn_q, evtEn_d, evt_q;
    logic                           start_q, pValid_q;
    logic [31:0]                    rdata_q, rdata_d;
    logic [NumJobRegs-1:0][31:0]    jobRegs_q;
`ifdef HWPE_CTRL_PERF_CNT_EN
    logic [31:0]                    perfCnt_q;
`endif

    logic [5:0] wordAddr, jobIdx;
    logic       wrEn, rdEn, jobHit;
    logic       unused_addr;

    assign wordAddr    = ctrl_req_i.q.addr[7:2];
    assign wrEn        = ctrl_req_i.q_valid & ctrl_req_i.q.write;
    assign rdEn        = ctrl_req_i.q_valid & ~ctrl_req_i.q.write;
    assign jobIdx      = wordAddr - AddrJobBase;
    assign jobHit      = (wordAddr >= AddrJobBase) && ({1'b0, wordAddr} < JobEnd);
    assign unused_addr = ^{ctrl_req_i.q.addr[31:8], ctrl_req_i.q.addr[1:0]};

    function automatic logic [31:0] strbMerge(input logic [31:0] oldVal, input logic [31:0] newVal,
                                              input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? newVal[8*b +: 8] : oldVal[8*b +: 8];
        end
        return res;
    endfunction

    // Read data is captured at acceptance so ACQUIRE/STATUS report the pre-update state.
    always_comb begin
        rdata_d = '0;
        evtEn_d = evtEn_q;
        if (wrEn && wordAddr == AddrEvtEn) begin
            for (int i = 0; i < NrCores; i++) begin
                evtEn_d[i] = ctrl_req_i.q.strb[i/8] ? ctrl_req_i.q.data[i] : evtEn_q[i];
            end
        end
        if (rdEn) begin
            case (wordAddr)
                AddrAcquire: rdata_d = (state_q == Idle) ? {24'h0, jobId_q} : 32'hFFFF_FFFF;
                AddrStatus:  rdata_d = {22'h0, state_q == Running, state_q == Locked, jobId_q};
                AddrEvtEn:   rdata_d = 32'(evtEn_q);
`ifdef HWPE_CTRL_PERF_CNT_EN
                AddrPerfCyc: rdata_d = perfCnt_q;
`endif
                default: begin
                    for (int i = 0; i < NumJobRegs; i++) begin
                        if (jobHit && jobIdx == 6'(i)) rdata_d = jobRegs_q[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            jobId_q   <= '0;
            evtEn_q   <= '0;
            evt_q     <= '0;
            start_q   <= 1'b0;
            pValid_q  <= 1'b0;
            rdata_q   <= '0;
            jobRegs_q <= '0;
`ifdef HWPE_CTRL_PERF_CNT_EN
            perfCnt_q <= '0;
`endif
        end else begin
            pValid_q <= ctrl_req_i.q_valid;
            rdata_q  <= rdata_d;
            start_q  <= 1'b0;
            evt_q    <= '0;
            evtEn_q  <= evtEn_d;
            if (wrEn && state_q == Locked) begin
                for (int i = 0; i < NumJobRegs; i++) begin
                    if (jobHit && jobIdx == 6'(i)) begin
                        jobRegs_q[i] <= strbMerge(jobRegs_q[i], ctrl_req_i.q.data, ctrl_req_i.q.strb);
                    end
                end
            end
            // Soft clear overrides everything, including a done_i arriving in the same cycle.
            if (wrEn && wordAddr == AddrSoftClr) begin
                state_q   <= Idle;
                jobRegs_q <= '0;
            end else begin
                case (state_q)
                    Idle: if (rdEn && wordAddr == AddrAcquire) state_q <= Locked;
                    Locked: begin
                        if (wrEn && wordAddr == AddrTrigger) begin
                            state_q <= Running;
                            start_q <= 1'b1;
`ifdef HWPE_CTRL_PERF_CNT_EN
                            perfCnt_q <= '0;
`endif
                        end
                    end
                    Running: begin
`ifdef HWPE_CTRL_PERF_CNT_EN
                        if (perfCnt_q != 32'hFFFF_FFFF) perfCnt_q <= perfCnt_q + 32'd1;
`endif
                        if (done_i) begin
                            state_q <= Done;
                            evt_q   <= evtEn_q;
                        end
                    end
                    Done: begin
                        state_q <= Idle;
                        jobId_q <= jobId_q + 8'd1;
                    end
                    default: state_q <= Idle;
                endcase
            end
        end
    end

    assign start_o    = start_q;
    assign evt_o      = evt_q;
    assign busy_o     = (state_q == Running);
    assign job_regs_o = jobRegs_q;

    always_comb begin
        ctrl_rsp_o         = '0;
        ctrl_rsp_o.q_ready = 1'b1;
        ctrl_rsp_o.p.data  = rdata_q;
        ctrl_rsp_o.p_valid = pValid_q;
    end

endmodule

// File: tb/tb_hwpe_ctrl_slave.sv
// Self-checking bench for hwpe_ctrl_slave: vector table, hand-written corner sequences and a
// randomized phase checked against a register-level reference model.
module tb_hwpe_ctrl_slave;
    import hwpe_ctrl_pkg::*;

    localparam int NrCores    = 9;
    localparam int NumJobRegs = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    periph_req_t              req;
    periph_rsp_t              rsp;
    logic [NumJobRegs*32-1:0] jobRegs;
    logic                     start, done, busy;
    logic [NrCores-1:0]       evt;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    hwpe_ctrl_slave #(.NrCores(NrCores), .NumJobRegs(NumJobRegs)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ctrl_req_i (req),
        .ctrl_rsp_o (rsp),
        .job_regs_o (jobRegs),
        .start_o    (start),
        .done_i     (done),
        .busy_o     (busy),
        .evt_o      (evt)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    // Reference model: the register map as seen by software.
    logic               mLocked, mRunning, mStartExp;
    logic [7:0]         mJobId;
    logic [NrCores-1:0] mEvtEn;
    logic [31:0]        mJob[NumJobRegs];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [31:0] rdata);
        @(negedge clk);
        req.q.addr  = addr;
        req.q.write = wr;
        req.q.data  = data;
        req.q.strb  = strb;
        req.q_valid = 1'b1;
        @(negedge clk);
        checkOutput("p_valid latency", 32'(rsp.p_valid), 32'd1);
        rdata       = rsp.p.data;
        req.q_valid = 1'b0;
        req.q.write = 1'b0;
    endtask

    task automatic addVec(input string n, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input logic [31:0] exp);
        vec_t v;
        v.name = n; v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic modelReset();
        mLocked = 1'b0; mRunning = 1'b0; mStartExp = 1'b0;
        mJobId = 8'h00; mEvtEn = '0;
        for (int i = 0; i < NumJobRegs; i++) mJob[i] = 32'h0;
    endtask

    function automatic logic [31:0] byteMerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelAccess(input logic wr, input logic [31:0] addr,
                                                input logic [31:0] data, input logic [3:0] strb);
        int          w;
        logic [31:0] exp;
        logic [31:0] tmp;
        w = int'(addr[7:2]);
        exp = 32'h0;
        mStartExp = 1'b0;
        if (wr) begin
            if (w == 0) begin
                if (mLocked) begin mLocked = 1'b0; mRunning = 1'b1; mStartExp = 1'b1; end
            end else if (w == 3) begin
                mLocked = 1'b0; mRunning = 1'b0;
                for (int i = 0; i < NumJobRegs; i++) mJob[i] = 32'h0;
            end else if (w == 4) begin
                tmp = byteMerge(32'(mEvtEn), data, strb);
                mEvtEn = tmp[NrCores-1:0];
            end else if (w >= 8 && w < 8 + NumJobRegs && mLocked) begin
                mJob[w-8] = byteMerge(mJob[w-8], data, strb);
            end
        end else begin
            if (w == 1) begin
                if (!mLocked && !mRunning) begin exp = {24'h0, mJobId}; mLocked = 1'b1; end
                else exp = 32'hFFFF_FFFF;
            end else if (w == 2) begin
                exp = {22'h0, mRunning, mLocked, mJobId};
            end else if (w == 4) begin
                exp = 32'(mEvtEn);
            end else if (w >= 8 && w < 8 + NumJobRegs) begin
                exp = mJob[w-8];
            end
        end
        return exp;
    endfunction

    task automatic pulseDoneChecked();
        logic [NrCores-1:0] expEvt;
        expEvt = mRunning ? mEvtEn : '0;
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
        checkOutput("rand evt on done", 32'(evt), 32'(expEvt));
        checkOutput("rand busy after done", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("rand evt cleared", 32'(evt), 32'd0);
        if (mRunning) begin mRunning = 1'b0; mJobId = mJobId + 8'd1; end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] rd, addr, data, r, exp;
        logic        wr, expStart;
        logic [3:0]  strb;
        int          w;

        doReset();
        checkOutput("reset p_valid", 32'(rsp.p_valid), 32'd0);
        checkOutput("reset q_ready", 32'(rsp.q_ready), 32'd1);
        checkOutput("reset start", 32'(start), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset evt", 32'(evt), 32'd0);
        checkOutput("reset jobregs", 32'(|jobRegs), 32'd0);

        addVec("status after reset",    1'b0, 32'h08,  32'h0,         4'h0, 32'h0000_0000);
        addVec("acquire first",         1'b0, 32'h04,  32'h0,         4'h0, 32'h0000_0000);
        addVec("status locked",         1'b0, 32'h08,  32'h0,         4'h0, 32'h0000_0100);
        addVec("acquire twice",         1'b0, 32'h04,  32'h0,         4'h0, 32'hFFFF_FFFF);
        addVec("status still locked",   1'b0, 32'h08,  32'h0,         4'h0, 32'h0000_0100);
        addVec("acquire alias high",    1'b0, 32'h104, 32'h0,         4'h0, 32'hFFFF_FFFF);
        addVec("job0 write strb3",      1'b1, 32'h20,  32'hA5A5_0001, 4'h3, 32'h0000_0000);
        addVec("job0 read",             1'b0, 32'h20,  32'h0,         4'h0, 32'h0000_0001);
        addVec("job1 write strbC",      1'b1, 32'h24,  32'h1234_5678, 4'hC, 32'h0000_0000);
        addVec("job1 read",             1'b0, 32'h24,  32'h0,         4'h0, 32'h1234_0000);
        addVec("job7 read",             1'b0, 32'h3C,  32'h0,         4'h0, 32'h0000_0000);
        addVec("evten write byte0",     1'b1, 32'h10,  32'hFFFF_FFFF, 4'h1, 32'h0000_0000);
        addVec("evten read byte0",      1'b0, 32'h10,  32'h0,         4'h0, 32'h0000_00FF);
        addVec("evten write byte1",     1'b1, 32'h10,  32'h0000_0105, 4'h2, 32'h0000_0000);
        addVec("evten read upper0",     1'b0, 32'h10,  32'h0,         4'h0, 32'h0000_01FF);
        addVec("evten write 005",       1'b1, 32'h10,  32'h0000_0005, 4'hF, 32'h0000_0000);
        addVec("evten read 005",        1'b0, 32'h10,  32'h0,         4'h0, 32'h0000_0005);
        addVec("unmapped read",         1'b0, 32'h18,  32'h0,         4'h0, 32'h0000_0000);
        addVec("unmapped write",        1'b1, 32'h1C,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000);
        addVec("perf/unmapped at rst",  1'b0, 32'h14,  32'h0,         4'h0, 32'h0000_0000);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd);
            checkOutput(vecs[i].name, rd, vecs[i].exp);
        end
        checkOutput("job_regs_o job0", jobRegs[31:0], 32'h0000_0001);

        // Soft clear, then a job-register write in IDLE must be dropped.
        applyStimulus(1'b1, 32'h0C, 32'h0, 4'h0, rd);
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, rd);
        checkOutput("status after clear", rd, 32'h0000_0000);
        applyStimulus(1'b1, 32'h20, 32'hA5A5_0001, 4'h3, rd);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, rd);
        checkOutput("job0 idle write dropped", rd, 32'h0000_0000);

        // Full job with a zero-strobe trigger and done_i ten cycles after the trigger edge.
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, rd);
        checkOutput("acquire job0", rd, 32'h0000_0000);
        applyStimulus(1'b1, 32'h00, 32'h0, 4'h0, rd);
        checkOutput("start pulse", 32'(start), 32'd1);
        checkOutput("busy running", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("start one cycle", 32'(start), 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("evt quiet while running", 32'(evt), 32'd0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        checkOutput("evt on done", 32'(evt), 32'h005);
        checkOutput("busy in done", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("evt one cycle", 32'(evt), 32'd0);
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, rd);
        checkOutput("status job_id 1", rd, 32'h0000_0001);
`ifdef HWPE_CTRL_PERF_CNT_EN
        applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, rd);
        checkOutput("perf cycles", rd, 32'd10);
`endif

        // done_i while IDLE is ignored.
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
        checkOutput("stray done evt", 32'(evt), 32'd0);
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, rd);
        checkOutput("stray done status", rd, 32'h0000_0001);

        // Soft clear and done_i in the same cycle: clear wins.
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, rd);
        checkOutput("acquire job1", rd, 32'h0000_0001);
        applyStimulus(1'b1, 32'h00, 32'h0, 4'hF, rd);
        repeat (3) @(negedge clk);
        @(negedge clk);
        req.q.addr = 32'h0C; req.q.write = 1'b1; req.q.strb = 4'h0; req.q_valid = 1'b1;
        done = 1'b1;
        @(negedge clk);
        checkOutput("clear+done p_valid", 32'(rsp.p_valid), 32'd1);
        req.q_valid = 1'b0; req.q.write = 1'b0; done = 1'b0;
        checkOutput("clear+done evt", 32'(evt), 32'd0);
        checkOutput("clear+done busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("clear+done evt later", 32'(evt), 32'd0);
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, rd);
        checkOutput("clear+done status", rd, 32'h0000_0001);

        // Back-to-back read, write, read with q_valid held.
        @(negedge clk);
        checkOutput("b2b idle p_valid", 32'(rsp.p_valid), 32'd0);
        req.q.addr = 32'h08; req.q.write = 1'b0; req.q_valid = 1'b1;
        @(negedge clk);
        checkOutput("b2b p_valid 1", 32'(rsp.p_valid), 32'd1);
        checkOutput("b2b read status", rsp.p.data, 32'h0000_0001);
        req.q.addr = 32'h10; req.q.write = 1'b1; req.q.data = 32'h0000_00F0; req.q.strb = 4'hF;
        @(negedge clk);
        checkOutput("b2b p_valid 2", 32'(rsp.p_valid), 32'd1);
        checkOutput("b2b write data", rsp.p.data, 32'h0);
        req.q.write = 1'b0;
        @(negedge clk);
        checkOutput("b2b p_valid 3", 32'(rsp.p_valid), 32'd1);
        checkOutput("b2b read evten", rsp.p.data, 32'h0000_00F0);
        req.q_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b p_valid drop", 32'(rsp.p_valid), 32'd0);

        // Asynchronous reset while RUNNING with a response pending.
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, rd);
        applyStimulus(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, rd);
        applyStimulus(1'b1, 32'h00, 32'h0, 4'hF, rd);
        @(negedge clk);
        req.q.addr = 32'h08; req.q.write = 1'b0; req.q_valid = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst p_valid", 32'(rsp.p_valid), 32'd0);
        checkOutput("async rst busy", 32'(busy), 32'd0);
        checkOutput("async rst jobregs", 32'(|jobRegs), 32'd0);
        req.q_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, rd);
        checkOutput("status after async rst", rd, 32'h0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd);
        checkOutput("evten after async rst", rd, 32'h0);

        // 256 complete jobs: job_id wraps back to 0.
        for (int j = 0; j < 256; j++) begin
            applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, rd);
            checkOutput("wrap acquire id", rd, 32'(j));
            applyStimulus(1'b1, 32'h00, 32'h0, 4'hF, rd);
            @(negedge clk); done = 1'b1;
            @(negedge clk); done = 1'b0;
            @(negedge clk);
        end
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, rd);
        checkOutput("job_id wrapped", rd, 32'h0000_0000);

        // Randomized accesses against the reference model.
        doReset();
        modelReset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            w = $urandom_range(0, 17);
`ifdef HWPE_CTRL_PERF_CNT_EN
            if (w == 5) w = 6;
`endif
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom_range(0, 1);
                wr = (w == 0);
            end
            if (w == 3 && $urandom_range(0, 3) != 0) begin
                w = 1; wr = 1'b0;
            end
            addr = {r[31:8], 6'(w), r[1:0]};
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            exp = modelAccess(wr, addr, data, strb);
            expStart = mStartExp;
            applyStimulus(wr, addr, data, strb, rd);
            checkOutput("rand rdata", rd, exp);
            checkOutput("rand start", 32'(start), 32'(expStart));
            checkOutput("rand busy", 32'(busy), 32'(mRunning));
            if ($urandom_range(0, 3) == 0) pulseDoneChecked();
        end
        @(negedge clk);
        for (int i = 0; i < NumJobRegs; i++) begin
            checkOutput("rand job_regs_o", jobRegs[32*i +: 32], mJob[i]);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
